// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave that turns each WB cycle into one rrq/wrq command toward hyperbus_fifo.
// Partial-byte writes become read-modify-write; a response timer guards against a hung Hyperbus side.
module hyperbus_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    rrq,
    output logic                    wrq,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   tx_dat_o,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_dat_i,
    input  logic                    rx_valid
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RMW_RD,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [1:0]            r_stale_rd;
    logic [1:0]            r_stale_wr;
    logic                  r_rrq;
    logic                  r_wrq;
    logic                  r_ack;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_tx_dat;
    logic [DATA_WIDTH-1:0] r_rd_dat;

    logic                  w_req;
    logic                  w_full;
    logic                  w_rx_stale;
    logic                  w_tx_stale;
    logic                  w_rx_resp;
    logic                  w_tx_resp;
    logic                  w_timeout;
    logic                  w_rd_abandon;
    logic                  w_wr_abandon;
    logic [DATA_WIDTH-1:0] w_merge;
    logic                  w_unused;

    // Halfword addressing drops the byte-lane bit.
    assign w_unused   = wb_adr_i[0];

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_full     = &wb_sel_i;
    assign w_rx_stale = rx_valid && (r_stale_rd != 2'd0);
    assign w_tx_stale = tx_ready && (r_stale_wr != 2'd0);
    assign w_rx_resp  = rx_valid && (r_stale_rd == 2'd0);
    assign w_tx_resp  = tx_ready && (r_stale_wr == 2'd0);
    assign w_timeout  = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT));

    // A response still owed by the FIFO is abandoned on timeout or master abort.
    assign w_rd_abandon = ((r_state == S_RD_WAIT) || (r_state == S_RMW_RD)) &&
                          !w_rx_resp && (!wb_cyc_i || w_timeout);
    assign w_wr_abandon = (r_state == S_WR_WAIT) && !w_tx_resp && (!wb_cyc_i || w_timeout);

    always_comb begin
        // NOTE: assign a default before the loop so no path leaves w_merge unassigned (no latch).
        w_merge = '0;
        for (int b = 0; b < SW; b++) begin
            w_merge[8*b +: 8] = wb_sel_i[b] ? wb_dat_i[8*b +: 8] : rx_dat_i[8*b +: 8];
        end
    end

    function automatic logic [1:0] stale_next(input logic [1:0] cnt, input logic inc, input logic dec);
        if (inc && !dec) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
        if (dec && !inc) return cnt - 2'd1;
        return cnt;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_stale_rd <= 2'd0;
            r_stale_wr <= 2'd0;
            r_rrq      <= 1'b0;
            r_wrq      <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_adr      <= '0;
            r_tx_dat   <= '0;
            r_rd_dat   <= '0;
        end else begin
            r_rrq      <= 1'b0;
            r_wrq      <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_stale_rd <= stale_next(r_stale_rd, w_rd_abandon, w_rx_stale);
            r_stale_wr <= stale_next(r_stale_wr, w_wr_abandon, w_tx_stale);

            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_req) begin
                        r_adr <= {1'b0, wb_adr_i[ADDR_WIDTH-1:1]};
                        if (!wb_we_i) begin
                            r_rrq   <= 1'b1;
                            r_state <= S_RD_WAIT;
                        end else if (w_full) begin
                            r_wrq    <= 1'b1;
                            r_tx_dat <= wb_dat_i;
                            r_state  <= S_WR_WAIT;
                        end else begin
                            r_rrq   <= 1'b1;
                            r_state <= S_RMW_RD;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (w_rx_resp) begin
                        if (wb_cyc_i) begin
                            r_rd_dat <= rx_dat_i;
                            r_ack    <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (!wb_cyc_i) begin
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RMW_RD: begin
                    if (w_rx_resp) begin
                        if (wb_cyc_i) begin
                            r_tx_dat <= w_merge;
                            r_wrq    <= 1'b1;
                            r_timer  <= '0;
                            r_state  <= S_WR_WAIT;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (!wb_cyc_i) begin
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WR_WAIT: begin
                    if (w_tx_resp) begin
                        r_ack   <= wb_cyc_i;
                        r_state <= S_DONE;
                    end else if (!wb_cyc_i) begin
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                // One dead cycle lets the master drop stb before a new command can start.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rrq      = r_rrq;
    assign wrq      = r_wrq;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign adr_o    = r_adr;
    assign tx_dat_o = r_tx_dat;
    assign wb_dat_o = r_rd_dat;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Self-checking bench for hyperbus_wb_bridge: directed vector table, timeout/abort/reset
// sequences, and randomized transactions checked against a transaction-level model.
module tb_hyperbus_wb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          rrq;
    logic          wrq;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] tx_dat_o;
    logic          tx_ready;
    logic [DW-1:0] rx_dat_i;
    logic          rx_valid;

    hyperbus_wb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .rrq(rrq), .wrq(wrq), .adr_o(adr_o), .tx_dat_o(tx_dat_o), .tx_ready(tx_ready),
        .rx_dat_i(rx_dat_i), .rx_valid(rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rx;
        int          delay;     // cycles from command pulse to response; 0 = never respond
        int          exp_rrq;
        int          exp_wrq;
        logic [31:0] exp_adr;
        logic [31:0] exp_tx;
        logic [31:0] exp_rdat;
    } vec_t;

    typedef struct {
        int          n_rrq;
        int          n_wrq;
        int          n_ack;
        int          n_err;
        int          t_first;
        int          t_last;
        int          t_end;
        logic [31:0] adr_r;
        logic [31:0] adr_w;
        logic [31:0] tx;
        logic [31:0] rdat;
        bit          done;
    } res_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: byte lanes chosen by sel come from the write data, the rest from memory.
    function automatic vec_t mk(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [31:0] rx, input int delay);
        vec_t        v;
        logic [31:0] mask;
        mask = 32'h0;
        if (sel[0]) mask = mask + 32'h0000_00FF;
        if (sel[1]) mask = mask + 32'h0000_FF00;
        if (sel[2]) mask = mask + 32'h00FF_0000;
        if (sel[3]) mask = mask + 32'hFF00_0000;
        v.we       = we;
        v.adr      = adr;
        v.dat      = dat;
        v.sel      = sel;
        v.rx       = rx;
        v.delay    = delay;
        v.exp_rrq  = (!we || sel != 4'hF) ? 1 : 0;
        v.exp_wrq  = we ? 1 : 0;
        v.exp_adr  = adr / 2;
        v.exp_tx   = (sel == 4'hF) ? dat : ((dat & mask) | (rx & ~mask));
        v.exp_rdat = we ? 32'h0 : rx;
        return v;
    endfunction

    // Acts as WB master and as the FIFO responder for one WB cycle.
    task automatic run_txn(input vec_t v, input bit pre_junk, input bit hold, input int abort_at,
                           output res_t r);
        int rx_cnt, tx_cnt, junk_at, end_at;
        bit junk_rx;
        r = '{default: 0};
        r.t_first = -1;
        rx_cnt = 0; tx_cnt = 0; junk_at = -1; end_at = -1; junk_rx = 1'b0;
        wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel; wb_we_i = v.we;
        wb_cyc_i = 1'b1;  wb_stb_i = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0; tx_ready = 1'b0;
            if (rx_cnt > 0) begin
                rx_cnt--;
                if (rx_cnt == 0) begin rx_valid = 1'b1; rx_dat_i = v.rx; end
            end
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_ready = 1'b1;
            end
            if (junk_at == i) begin
                if (junk_rx) begin rx_valid = 1'b1; rx_dat_i = 32'hBAD0_BAD0; end
                else tx_ready = 1'b1;
            end
            if (rrq) begin
                r.n_rrq++; r.adr_r = adr_o; r.t_last = i; rx_cnt = v.delay;
                if (r.t_first < 0) r.t_first = i;
            end
            if (wrq) begin
                r.n_wrq++; r.adr_w = adr_o; r.tx = tx_dat_o; r.t_last = i; tx_cnt = v.delay;
                if (r.t_first < 0) r.t_first = i;
            end
            if (pre_junk && r.t_first == i) begin junk_at = i + 1; junk_rx = rrq; end
            if (wb_ack_o) begin r.n_ack++; r.rdat = wb_dat_o; r.t_end = i; end
            if (wb_err_o) begin r.n_err++; r.t_end = i; end
            if ((wb_ack_o || wb_err_o) && end_at < 0) end_at = i + (hold ? 3 : 2);
            if (end_at > 0 && i == end_at - 2) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
            if (abort_at > 0 && r.t_first >= 0 && i == r.t_first + abort_at && end_at < 0) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end_at = i + 4;
            end
            if (i == end_at) begin r.done = 1'b1; break; end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic verify(input string tag, input vec_t v, input res_t r);
        check($sformatf("%s.done", tag), 64'(r.done), 64'd1);
        check($sformatf("%s.ack", tag), 64'(r.n_ack), 64'd1);
        check($sformatf("%s.err", tag), 64'(r.n_err), 64'd0);
        check($sformatf("%s.rrq_count", tag), 64'(r.n_rrq), 64'(v.exp_rrq));
        check($sformatf("%s.wrq_count", tag), 64'(r.n_wrq), 64'(v.exp_wrq));
        if (v.exp_rrq != 0) check($sformatf("%s.adr_rd", tag), 64'(r.adr_r), 64'(v.exp_adr));
        if (v.we) begin
            check($sformatf("%s.adr_wr", tag), 64'(r.adr_w), 64'(v.exp_adr));
            check($sformatf("%s.tx_dat", tag), 64'(r.tx), 64'(v.exp_tx));
        end else begin
            check($sformatf("%s.rd_dat", tag), 64'(r.rdat), 64'(v.exp_rdat));
        end
        check($sformatf("%s.cmd_lat", tag), 64'(r.t_first), 64'd1);
        check($sformatf("%s.ack_lat", tag), 64'(r.t_end - r.t_last), 64'(v.delay + 1));
    endtask

    vec_t tbl[6];
    vec_t v;
    res_t r;

    initial begin
        rst_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_dat_i = '0;

        //          we  adr           dat           sel   rx            d  rrq wrq adr           tx            rdat
        tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'hDEAD_BEEF, 5, 1, 0, 32'h0000_0080, 32'h0,        32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 32'h0,        4, 0, 1, 32'h0000_0004, 32'h1234_5678, 32'h0};
        tbl[2] = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h1122_3344, 3, 1, 1, 32'h0000_0010, 32'h11BB_33DD, 32'h0};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0102_0304, 4'h0, 32'hA5A5_A5A5, 1, 1, 1, 32'h7FFF_FFFF, 32'hA5A5_A5A5, 32'h0};
        tbl[4] = '{1'b1, 32'h0000_0003, 32'hFF00_0000, 4'h8, 32'h0011_2233, 2, 1, 1, 32'h0000_0001, 32'hFF11_2233, 32'h0};
        tbl[5] = '{1'b0, 32'h0000_0001, 32'h0,        4'h3, 32'h5A5A_A5A5, 1, 1, 0, 32'h0000_0000, 32'h0,        32'h5A5A_A5A5};

        repeat (3) @(posedge clk);
        #1;
        check("reset.rrq", 64'(rrq), 64'd0);
        check("reset.wrq", 64'(wrq), 64'd0);
        check("reset.ack", 64'(wb_ack_o), 64'd0);
        check("reset.err", 64'(wb_err_o), 64'd0);
        check("reset.adr_o", 64'(adr_o), 64'd0);
        check("reset.tx_dat", 64'(tx_dat_o), 64'd0);
        check("reset.wb_dat", 64'(wb_dat_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            run_txn(tbl[k], 1'b0, 1'b0, 0, r);
            verify($sformatf("vec%0d", k), tbl[k], r);
        end

        // stb held through DONE must not start a second command
        v = mk(1'b0, 32'h40, 32'h0, 4'hF, 32'h0BAD_F00D, 2);
        run_txn(v, 1'b0, 1'b1, 0, r);
        verify("hold_rd", v, r);
        v = mk(1'b1, 32'h44, 32'h7777_1111, 4'hF, 32'h0, 3);
        run_txn(v, 1'b0, 1'b1, 0, r);
        verify("hold_wr", v, r);

        // read timeout, then the late response must be discarded during the next read
        v = mk(1'b0, 32'h100, 32'h0, 4'hF, 32'h0, 0);
        run_txn(v, 1'b0, 1'b0, 0, r);
        check("to_rd.err", 64'(r.n_err), 64'd1);
        check("to_rd.ack", 64'(r.n_ack), 64'd0);
        check("to_rd.err_lat", 64'(r.t_end - r.t_first), 64'(TO + 1));
        v = mk(1'b0, 32'h200, 32'h0, 4'hF, 32'hCAFE_F00D, 4);
        run_txn(v, 1'b1, 1'b0, 0, r);
        verify("after_to_rd", v, r);

        // write timeout, then a stale tx_ready must not ack the next write
        v = mk(1'b1, 32'h300, 32'h1111_2222, 4'hF, 32'h0, 0);
        run_txn(v, 1'b0, 1'b0, 0, r);
        check("to_wr.err", 64'(r.n_err), 64'd1);
        check("to_wr.ack", 64'(r.n_ack), 64'd0);
        v = mk(1'b1, 32'h304, 32'h3333_4444, 4'hF, 32'h0, 5);
        run_txn(v, 1'b1, 1'b0, 0, r);
        verify("after_to_wr", v, r);

        // response in the timeout cycle wins: ack, no err, nothing stale afterwards
        v = mk(1'b0, 32'h400, 32'h0, 4'hF, 32'h1357_9BDF, TO);
        run_txn(v, 1'b0, 1'b0, 0, r);
        verify("edge_to", v, r);
        v = mk(1'b0, 32'h404, 32'h0, 4'hF, 32'h2468_ACE0, 2);
        run_txn(v, 1'b0, 1'b0, 0, r);
        verify("after_edge_to", v, r);

        // master aborts during read and write waits
        v = mk(1'b0, 32'h500, 32'h0, 4'hF, 32'h0, 0);
        run_txn(v, 1'b0, 1'b0, 3, r);
        check("abort_rd.ack", 64'(r.n_ack), 64'd0);
        check("abort_rd.err", 64'(r.n_err), 64'd0);
        v = mk(1'b0, 32'h504, 32'h0, 4'hF, 32'h5555_AAAA, 3);
        run_txn(v, 1'b1, 1'b0, 0, r);
        verify("after_abort_rd", v, r);
        v = mk(1'b1, 32'h600, 32'h6666_0000, 4'hF, 32'h0, 0);
        run_txn(v, 1'b0, 1'b0, 3, r);
        check("abort_wr.ack", 64'(r.n_ack), 64'd0);
        check("abort_wr.err", 64'(r.n_err), 64'd0);
        v = mk(1'b1, 32'h604, 32'h6666_1111, 4'hF, 32'h0, 4);
        run_txn(v, 1'b1, 1'b0, 0, r);
        verify("after_abort_wr", v, r);

        // timeout in the read phase of a read-modify-write leaves a stale read
        v = mk(1'b1, 32'h700, 32'h7777_7777, 4'h2, 32'h0, 0);
        run_txn(v, 1'b0, 1'b0, 0, r);
        check("to_rmw.err", 64'(r.n_err), 64'd1);
        check("to_rmw.wrq", 64'(r.n_wrq), 64'd0);
        v = mk(1'b0, 32'h704, 32'h0, 4'hF, 32'h8888_9999, 3);
        run_txn(v, 1'b1, 1'b0, 0, r);
        verify("after_to_rmw", v, r);

        // reset asserted while waiting for tx_ready clears all outputs immediately
        wb_adr_i = 32'h8; wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        check("rst_seq.wrq", 64'(wrq), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid.rrq", 64'(rrq), 64'd0);
        check("rst_mid.wrq", 64'(wrq), 64'd0);
        check("rst_mid.ack", 64'(wb_ack_o), 64'd0);
        check("rst_mid.err", 64'(wb_err_o), 64'd0);
        check("rst_mid.adr_o", 64'(adr_o), 64'd0);
        check("rst_mid.tx_dat", 64'(tx_dat_o), 64'd0);
        check("rst_mid.wb_dat", 64'(wb_dat_o), 64'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = mk(1'b0, 32'h800, 32'h0, 4'hF, 32'h0F0F_F0F0, 3);
        run_txn(v, 1'b0, 1'b0, 0, r);
        verify("after_rst", v, r);

        for (int k = 0; k < 40; k++) begin
            logic [3:0] sel;
            sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) sel = 4'hF;
            v = mk(1'($urandom_range(0, 1)), $urandom, $urandom, sel, $urandom,
                   int'($urandom_range(1, 10)));
            run_txn(v, 1'b0, 1'b0, 0, r);
            verify($sformatf("rand%0d", k), v, r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
